// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment constants and receiver state type
package seg7_pkg;

   localparam int SEG_W = 7;

   // Active-high segment patterns {a,b,c,d,e,f,g}, bit6 = a
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b1111011;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      OUT
   } state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// rtl/seg7_digit_decode.sv - combinational active-high 7-segment pattern to BCD lookup
module seg7_digit_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] in_seg,
   output logic             hit,
   output logic [3:0]       bcd
);

   // Exact match against the ten digit glyphs; anything else is a miss
   always_comb begin
      hit = 1'b1;
      bcd = 4'd0;
      case (in_seg)
         SEG_0:   bcd = 4'd0;
         SEG_1:   bcd = 4'd1;
         SEG_2:   bcd = 4'd2;
         SEG_3:   bcd = 4'd3;
         SEG_4:   bcd = 4'd4;
         SEG_5:   bcd = 4'd5;
         SEG_6:   bcd = 4'd6;
         SEG_7:   bcd = 4'd7;
         SEG_8:   bcd = 4'd8;
         SEG_9:   bcd = 4'd9;
         default: hit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_num_decoder.sv
// rtl/seg7_num_decoder.sv - 7-segment digit frame receiver to binary value; SEG7_DEC_ACTIVE_LOW_EN selects active-low segments
module seg7_num_decoder
   import seg7_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int RES_W      = 14,
   parameter int CNT_W      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEG_W-1:0] in_seg,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RES_W-1:0] out_value,
   output logic [CNT_W-1:0] out_digits,
   output logic             out_err
);

   localparam logic [RES_W+3:0] TEN     = (RES_W+4)'(10);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state;
   state_t           state_next;
   logic [RES_W-1:0] acc;
   logic [RES_W-1:0] acc_next;
   logic [3:0]       mac_unused;
   logic [CNT_W-1:0] count;
   logic             err;
   logic [SEG_W-1:0] seg_eff;
   logic             hit;
   logic [3:0]       bcd;
   logic             accept;
   logic             full;

`ifdef SEG7_DEC_ACTIVE_LOW_EN
   assign seg_eff = ~in_seg;
`else
   assign seg_eff = in_seg;
`endif

   seg7_digit_decode u_digit_decode (
      .in_seg (seg_eff),
      .hit    (hit),
      .bcd    (bcd)
   );

   assign accept = in_valid && in_ready;
   assign full   = (count == CNT_MAX);

   // Widen before multiply so the carry-out is explicit, then keep the low RES_W bits
   assign {mac_unused, acc_next} = {4'b0000, acc} * TEN + {{RES_W{1'b0}}, bcd};

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake/result outputs; result is only exposed while holding in OUT
   always_comb begin
      state_next = state;
      in_ready   = 1'b1;
      out_valid  = 1'b0;
      out_value  = '0;
      out_digits = '0;
      out_err    = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = in_last ? OUT : ACC;
            end
         end
         ACC: begin
            if (accept && in_last) begin
               state_next = OUT;
            end
         end
         OUT: begin
            in_ready   = 1'b0;
            out_valid  = 1'b1;
            out_value  = err ? '0 : acc;
            out_digits = count;
            out_err    = err;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Frame accumulator, digit count and sticky error; cleared when the result is taken
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         count <= '0;
         err   <= 1'b0;
      end else if (state == OUT) begin
         if (out_ready) begin
            acc   <= '0;
            count <= '0;
            err   <= 1'b0;
         end
      end else if (accept) begin
         if (full) begin
            err <= 1'b1;
         end else begin
            count <= count + CNT_ONE;
            if (hit) begin
               acc <= acc_next;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_num_decoder.sv
// tb/tb_seg7_num_decoder.sv - self-checking bench for seg7_num_decoder
module tb_seg7_num_decoder;

   localparam int MAXD = 4;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_seg;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [13:0] out_value;
   logic [2:0]  out_digits;
   logic        out_err;

   int checks;
   int failures;

   seg7_num_decoder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_seg     (in_seg),
      .in_last    (in_last),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_value  (out_value),
      .out_digits (out_digits),
      .out_err    (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                            7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   typedef struct {
      int             n;
      logic [0:5][6:0] segs;
      int             value;
      int             digits;
      bit             err;
      int             hold;
   } vec_t;

   vec_t       tbl [7];
   logic [6:0] fq [$];

   function automatic logic [6:0] enc(input logic [6:0] p);
`ifdef SEG7_DEC_ACTIVE_LOW_EN
      return ~p;
`else
      return p;
`endif
   endfunction

   function automatic int dec(input logic [6:0] p);
      for (int i = 0; i < 10; i++) begin
         if (pat[i] == p) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Reference: decimal value of the frame, digits capped, error on bad glyph or too many digits
   task automatic model(output int v, output int d, output bit e);
      v = 0;
      e = 1'b0;
      for (int i = 0; i < fq.size(); i++) begin
         if (i >= MAXD) begin
            e = 1'b1;
         end else if (dec(fq[i]) < 0) begin
            e = 1'b1;
         end else begin
            v = v * 10 + dec(fq[i]);
         end
      end
      d = (fq.size() > MAXD) ? MAXD : fq.size();
      if (e) v = 0;
   endtask

   // Streams fq back to back, checks one-cycle latency, holds the result, then releases it
   task automatic run_frame(input string name, input int ev, input int ed, input bit ee,
                            input int hold, input bit poke);
      int n;
      n = fq.size();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk({name, ".in_ready"}, int'(in_ready), 1);
         chk({name, ".early_valid"}, int'(out_valid), 0);
         in_valid = 1'b1;
         in_seg   = enc(fq[i]);
         in_last  = (i == n - 1);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk({name, ".out_valid"}, int'(out_valid), 1);
      chk({name, ".out_value"}, int'(out_value), ev);
      chk({name, ".out_digits"}, int'(out_digits), ed);
      chk({name, ".out_err"}, int'(out_err), int'(ee));
      for (int h = 0; h < hold; h++) begin
         if (poke) begin
            in_valid = 1'b1;
            in_seg   = enc(pat[8]);
            in_last  = 1'b1;
         end
         @(negedge clk);
         chk({name, ".hold_valid"}, int'(out_valid), 1);
         chk({name, ".hold_ready"}, int'(in_ready), 0);
         chk({name, ".hold_value"}, int'(out_value), ev);
         chk({name, ".hold_digits"}, int'(out_digits), ed);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({name, ".release_valid"}, int'(out_valid), 0);
      chk({name, ".release_ready"}, int'(in_ready), 1);
   endtask

   task automatic chk_reset_vals(input string name);
      chk({name, ".in_ready"}, int'(in_ready), 1);
      chk({name, ".out_valid"}, int'(out_valid), 0);
      chk({name, ".out_value"}, int'(out_value), 0);
      chk({name, ".out_digits"}, int'(out_digits), 0);
      chk({name, ".out_err"}, int'(out_err), 0);
   endtask

   initial begin
      int ev, ed;
      bit ee;
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_seg    = 7'd0;
      in_last   = 1'b0;
      out_ready = 1'b0;

      tbl[0] = '{n: 2, segs: '{7'b0110000, 7'b0110011, 7'h0, 7'h0, 7'h0, 7'h0},
                 value: 14, digits: 2, err: 1'b0, hold: 0};
      tbl[1] = '{n: 2, segs: '{7'b1011111, 7'b1110000, 7'h0, 7'h0, 7'h0, 7'h0},
                 value: 67, digits: 2, err: 1'b0, hold: 5};
      tbl[2] = '{n: 3, segs: '{7'b1111111, 7'b1000000, 7'b1101101, 7'h0, 7'h0, 7'h0},
                 value: 0, digits: 3, err: 1'b1, hold: 1};
      tbl[3] = '{n: 5, segs: '{7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011, 7'h0},
                 value: 0, digits: 4, err: 1'b1, hold: 0};
      tbl[4] = '{n: 1, segs: '{7'b1111110, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0},
                 value: 0, digits: 1, err: 1'b0, hold: 0};
      tbl[5] = '{n: 4, segs: '{7'b1111011, 7'b1111011, 7'b1111011, 7'b1111011, 7'h0, 7'h0},
                 value: 9999, digits: 4, err: 1'b0, hold: 2};
      tbl[6] = '{n: 1, segs: '{7'b0000000, 7'h0, 7'h0, 7'h0, 7'h0, 7'h0},
                 value: 0, digits: 1, err: 1'b1, hold: 0};

      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      rst = 1'b0;

      for (int t = 0; t < 7; t++) begin
         fq.delete();
         for (int i = 0; i < tbl[t].n; i++) fq.push_back(tbl[t].segs[i]);
         run_frame($sformatf("vec%0d", t), tbl[t].value, tbl[t].digits, tbl[t].err,
                   tbl[t].hold, (t == 1));
      end

      // Reset after two accepted digits discards the partial frame
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_seg   = enc(7'b1111011);
         in_last  = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("rst_mid");
      fq.delete();
      fq.push_back(7'b1101101);
      run_frame("after_rst_mid", 2, 1, 1'b0, 0, 1'b0);

      // Reset while a result is pending
      @(negedge clk);
      in_valid = 1'b1;
      in_seg   = enc(7'b1111001);
      in_last  = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("rst_out.pre_valid", int'(out_valid), 1);
      chk("rst_out.pre_value", int'(out_value), 3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("rst_out");
      fq.delete();
      fq.push_back(7'b0110000);
      fq.push_back(7'b1111110);
      run_frame("after_rst_out", 10, 2, 1'b0, 0, 1'b0);

      // Random frames against the reference model
      for (int r = 0; r < 40; r++) begin
         int n;
         n = $urandom_range(1, 6);
         fq.delete();
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 9) == 0) fq.push_back(7'($urandom_range(0, 127)));
            else fq.push_back(pat[$urandom_range(0, 9)]);
         end
         model(ev, ed, ee);
         run_frame($sformatf("rand%0d", r), ev, ed, ee, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_num_decoder.md
Name: seg7_num_decoder

Overview:
- Sequential receiver for 7-segment-encoded decimal digits; the inverse of the team's binary-to-7-segment encoding path.
- Accepts a frame of digit patterns, most significant digit first, over a valid/ready handshake.
- Decodes each pattern to BCD and accumulates the frame into a binary value.
- Presents the result with digit count and error flag on a valid/ready output.
- Sits between 7-segment producers (e.g. adder output digits) and binary consumers/checkers.

Parameters:
- MAX_DIGITS, 4: maximum digits per frame.
- RES_W, 14: result width; must satisfy 2^RES_W > 10^MAX_DIGITS - 1.
- CNT_W, 3: digit-count width; must hold MAX_DIGITS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  seg pattern valid.
- in_ready  out  1  block can accept a pattern.
- in_seg  in  7  segments {a,b,c,d,e,f,g}, bit6=a, 1=segment lit.
- in_last  in  1  accepted pattern is the final digit of the frame.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_value  out  RES_W  binary value of frame.
- out_digits  out  CNT_W  digits accepted in frame, including bad ones, saturating at MAX_DIGITS.
- out_err  out  1  frame contained invalid pattern or overflowed.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_value=0, out_digits=0, out_err=0, accumulator=0, count=0, sticky err=0.
- Decode table (all others invalid): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
- Accept: a pattern is taken on a cycle with in_valid && in_ready. in_seg and in_last are sampled only then.
- in_ready = (state != OUT). No overlap between frames.
- States:
  - IDLE: first accept goes to ACC, or straight to OUT if in_last=1.
  - ACC: accumulate each accept; an accept with in_last=1 goes to OUT.
  - OUT: out_valid=1, outputs held stable; out_ready=1 goes to IDLE, clears acc/count/err.
- Arithmetic per valid accept: acc <= acc*10 + digit, computed at RES_W+4 bits, then truncated.
- Invalid pattern: err is set sticky; acc is unchanged; count still increments.
- Overflow: an accept when count==MAX_DIGITS sets err; acc and count are unchanged.
- Error frames: if err is set at OUT entry, out_value=0 and out_err=1.
- Latency: out_valid rises the cycle after the last digit is accepted. Full throughput within a frame is one digit per cycle.
- Backpressure: out_valid may stay high indefinitely; the output is neither dropped nor overwritten.
- Single-digit frame (first accept with in_last=1) is legal.
- Reset mid-frame or in OUT: everything returns to reset values next cycle; the partial frame is discarded.
- in_valid while in OUT is ignored; the producer must hold it.

Optional Feature:
- Macro SEG7_DEC_ACTIVE_LOW_EN.
- Defined: in_seg is active-low (common-anode wiring). The pattern is inverted before table lookup, e.g. 0001111 decodes as 7.
- Undefined: active-high as above.
- No other behaviour changes.

Decomposition:
- Package seg7_pkg:
  - SEG_W=7.
  - Localparams SEG_0..SEG_9 holding the active-high patterns above.
  - SEG_BLANK=0000000.
  - State enum typedef {IDLE, ACC, OUT}.
- Sub-module seg7_digit_decode: combinational, in_seg[6:0] to {hit, bcd[3:0]}, shared with other display blocks.
- Active-low inversion lives in the top level, not the sub-module.

Test Plan:
- Frame 0110000, then 0110011 with last, out_ready=1 → out_value=14, out_digits=2, out_err=0; out_valid one cycle after the last accept.
- Frame 1011111, 1110000 with last; out_ready held 0 for 5 cycles → out_valid, out_value=67 stable, in_ready=0 throughout; release → next cycle IDLE, in_ready=1.
- Frame 1111111, 1000000 (invalid), 1101101 with last → out_err=1, out_value=0, out_digits=3.
- Five valid digits 1111011 with last on the 5th, MAX_DIGITS=4 → out_err=1, out_value=0, out_digits=4.
- Single digit 1111110 with last → out_value=0, out_digits=1, out_err=0. Then assert rst mid-frame after two digits → outputs at reset values; the next frame 1101101 with last gives 2.
- SEG7_DEC_ACTIVE_LOW_EN defined: 1001111, 1001100 with last → out_value=14.
